// File: rtl/hold_interp_complex_pkg.sv
// Shared definitions for the complex zero-order-hold interpolator: FSM state
// encoding and the width helpers for the repeat count and repetition counter.
package hold_interp_complex_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Width of the len port; the boxcar averager sizes its length port the same way.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Counter only has to reach MAX_LEN-1; keep at least one bit.
  function automatic int cnt_width(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/hold_interp_complex.sv
// Complex zero-order-hold interpolator: each accepted {I,Q} sample is emitted
// L times on the output stream, with a same-cycle reload on the final beat.
module hold_interp_complex
  import hold_interp_complex_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MAX_LEN = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [len_width(MAX_LEN)-1:0] len,
  input  logic [2*WIDTH-1:0]            i_tdata,
  input  logic                          i_tlast,
  input  logic                          i_tvalid,
  output logic                          i_tready,
  output logic [2*WIDTH-1:0]            o_tdata,
  output logic                          o_tlast,
  output logic                          o_tvalid,
  input  logic                          o_tready
);

  localparam int LW = len_width(MAX_LEN);
  localparam int CW = cnt_width(MAX_LEN);

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_data;
  logic                 r_held_last;
  logic                 r_tlast;
  logic [LW-1:0]        r_len;
  logic [CW-1:0]        r_cnt;

  state_t               w_state_nxt;
  logic [2*WIDTH-1:0]   w_data_nxt;
  logic                 w_held_last_nxt;
  logic                 w_tlast_nxt;
  logic [LW-1:0]        w_len_nxt;
  logic [CW-1:0]        w_cnt_nxt;

  logic [LW-1:0]        w_eff_len;
  logic [CW-1:0]        w_cnt_inc;
  logic                 w_last_beat;
  logic                 w_accept;
  logic                 w_obeat;

  // Clamp the requested repeat count into 1..MAX_LEN.
  always_comb begin
    w_eff_len = len;
    if (len == {LW{1'b0}}) begin
      w_eff_len = LW'(1);
    end else if (len > LW'(MAX_LEN)) begin
      w_eff_len = LW'(MAX_LEN);
    end else begin
      w_eff_len = len;
    end
  end

  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_last_beat = (r_state == HOLD) && (LW'(r_cnt) == (r_len - LW'(1)));
  assign o_tvalid    = (r_state == HOLD);
  assign o_tdata     = r_data;
  assign o_tlast     = r_tlast;
  // Ready opens on the final repetition so the next sample loads without a bubble.
  assign i_tready    = (r_state == EMPTY) || (o_tready && w_last_beat);
  assign w_accept    = i_tvalid && i_tready;
  assign w_obeat     = o_tvalid && o_tready;

  // Next-state logic: reload on accept, count beats, drop to EMPTY after the last one.
  always_comb begin
    w_state_nxt     = r_state;
    w_data_nxt      = r_data;
    w_held_last_nxt = r_held_last;
    w_tlast_nxt     = r_tlast;
    w_len_nxt       = r_len;
    w_cnt_nxt       = r_cnt;
    if (w_accept) begin
      w_state_nxt     = HOLD;
      w_data_nxt      = i_tdata;
      w_held_last_nxt = i_tlast;
      w_len_nxt       = w_eff_len;
      w_cnt_nxt       = {CW{1'b0}};
      w_tlast_nxt     = i_tlast && (w_eff_len == LW'(1));
    end else if (w_obeat) begin
      if (w_last_beat) begin
        w_state_nxt = EMPTY;
        w_cnt_nxt   = {CW{1'b0}};
        w_tlast_nxt = 1'b0;
      end else begin
        w_cnt_nxt   = w_cnt_inc;
        w_tlast_nxt = r_held_last && (LW'(w_cnt_inc) == (r_len - LW'(1)));
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State and output registers; clear behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state     <= EMPTY;
      r_data      <= {(2*WIDTH){1'b0}};
      r_held_last <= 1'b0;
      r_tlast     <= 1'b0;
      r_len       <= LW'(1);
      r_cnt       <= {CW{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_data      <= w_data_nxt;
      r_held_last <= w_held_last_nxt;
      r_tlast     <= w_tlast_nxt;
      r_len       <= w_len_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

endmodule
